max_reduce_int32_stream: RTL

//   Streaming signed-max reduction stage that consumes one 32-bit signed element per

---
 rtl/max_reduce_int32_stream.sv | 97 +++++++++
 1 files changed

// File: rtl/max_reduce_int32_stream.sv
// Streaming signed-max reduction: one signed element per beat in, one
// {max, first index of max, element count} result out per vector.
module max_reduce_int32_stream #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic signed [WIDTH-1:0] acc;
    logic        [IDX_W-1:0] acc_idx;
    logic        [IDX_W-1:0] pos;
    logic        [IDX_W-1:0] count;
    logic                    accept;
    logic                    greater;

    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (v == {IDX_W{1'b1}}) ? v : v + IDX_W'(1);
    endfunction

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    // Strict compare: an equal value never displaces the earlier index.
    assign greater   = ($signed(in_data) > acc);

    assign out_max   = acc;
    assign out_idx   = acc_idx;
    assign out_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            acc_idx <= '0;
            pos     <= '0;
            count   <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc     <= $signed(in_data);
                acc_idx <= '0;
                pos     <= IDX_W'(1);
                count   <= IDX_W'(1);
            end else begin
                if (greater) begin
                    acc     <= $signed(in_data);
                    acc_idx <= pos;
                end
                pos   <= pos + IDX_W'(1);
                count <= sat_inc(count);
            end
        end
    end

endmodule
